// File: rtl/arrow_sequencer.sv
// arrow_sequencer: erases the arrow box in black, then forwards the selected drawer's pixels to the VGA adapter
module arrow_sequencer #(
   parameter int BOX_X0         = 71,
   parameter int BOX_Y0         = 56,
   parameter int BOX_W          = 16,
   parameter int BOX_H          = 16,
   parameter int TIMEOUT_CYCLES = 60_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_dir,
   input  logic [2:0]  cmd_colour,
   input  logic [31:0] drw_x,
   input  logic [27:0] drw_y,
   input  logic [3:0]  drw_plot,
   input  logic [3:0]  drw_done,
   output logic [3:0]  drw_en,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        busy,
   output logic        done_pulse,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;
   state_t      state, state_n;
   logic [4:0]  ex, ey, ex_n, ey_n;
   logic [25:0] tcnt, tcnt_n;
   logic [1:0]  dir_q, dir_n;
   logic [2:0]  colour_q, colour_n;
   logic        terr, terr_n;
   logic        ex_last, ey_last;

   assign ex_last = ex == 5'(BOX_W - 1);
   assign ey_last = ey == 5'(BOX_H - 1);

   always_ff @(posedge clk)
      if (!reset_n) begin
         state    <= IDLE;
         ex       <= '0;
         ey       <= '0;
         tcnt     <= '0;
         dir_q    <= '0;
         colour_q <= '0;
         terr     <= 1'b0;
      end else begin
         state    <= state_n;
         ex       <= ex_n;
         ey       <= ey_n;
         tcnt     <= tcnt_n;
         dir_q    <= dir_n;
         colour_q <= colour_n;
         terr     <= terr_n;
      end

   always_comb begin
      state_n     = state;
      ex_n        = ex;
      ey_n        = ey;
      tcnt_n      = '0;
      dir_n       = dir_q;
      colour_n    = colour_q;
      terr_n      = terr;
      cmd_ready   = 1'b0;
      drw_en      = '0;
      vga_x       = '0;
      vga_y       = '0;
      vga_colour  = '0;
      vga_plot    = 1'b0;
      busy        = state != IDLE;
      done_pulse  = 1'b0;
      timeout_err = terr;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               dir_n    = cmd_dir;
               colour_n = cmd_colour;
               ex_n     = '0;
               ey_n     = '0;
               terr_n   = 1'b0;
               state_n  = ERASE;
            end
         end
         ERASE: begin
            vga_plot = 1'b1;
            vga_x    = 8'(BOX_X0 + int'(ex));
            vga_y    = 7'(BOX_Y0 + int'(ey));
            ex_n     = ex_last ? '0 : ex + 5'd1;
            ey_n     = ex_last ? ey + 5'd1 : ey;
            if (ex_last && ey_last) state_n = DRAW;
         end
         DRAW: begin
            drw_en     = 4'b0001 << dir_q;
            vga_colour = colour_q;
            vga_x      = drw_x[8*dir_q +: 8];
            vga_y      = drw_y[7*dir_q +: 7];
            vga_plot   = drw_plot[dir_q];
            tcnt_n     = tcnt + 26'd1;
            // done has priority over a timeout landing on the same cycle
            if (drw_done[dir_q]) state_n = FINISH;
            else if (tcnt == 26'(TIMEOUT_CYCLES - 1)) begin
               terr_n  = 1'b1;
               state_n = FINISH;
            end
         end
         FINISH: begin
            done_pulse = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // every output is forced low for as long as reset is held
      if (!reset_n) begin
         cmd_ready   = 1'b0;
         drw_en      = '0;
         vga_x       = '0;
         vga_y       = '0;
         vga_colour  = '0;
         vga_plot    = 1'b0;
         busy        = 1'b0;
         done_pulse  = 1'b0;
         timeout_err = 1'b0;
      end
   end
endmodule

// File: tb/tb_arrow_sequencer.sv
// tb_arrow_sequencer: randomized bench comparing two sequencer configurations against a command-level reference model
module tb_arrow_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_dir = '0;
   logic [2:0]  cmd_colour = '0;
   logic [31:0] drw_x = '0;
   logic [27:0] drw_y = '0;
   logic [3:0]  drw_plot = '0;
   logic [3:0]  drw_done = '0;
   logic        sel = 1'b0;

   logic       a_cmd_ready, a_vga_plot, a_busy, a_done_pulse, a_timeout_err;
   logic [3:0] a_drw_en;
   logic [7:0] a_vga_x;
   logic [6:0] a_vga_y;
   logic [2:0] a_vga_colour;
   logic       b_cmd_ready, b_vga_plot, b_busy, b_done_pulse, b_timeout_err;
   logic [3:0] b_drw_en;
   logic [7:0] b_vga_x;
   logic [6:0] b_vga_y;
   logic [2:0] b_vga_colour;
   logic [26:0] outs;

   int n_chk = 0, n_err = 0;
   int W = 16, H = 16, X0 = 71, Y0 = 56, T = 20;
   bit m_busy = 0, m_fin = 0, m_terr = 0;
   int m_age = 0;
   logic [1:0] m_dir = '0;
   logic [2:0] m_col = '0;
   int done_mode = 0, done_k = 0, rst_pix = -1, fdir = -1, fcol = -1;
   bit hold_valid = 0, pix = 0, rst_force = 0;

   always #5 clk = ~clk;

   arrow_sequencer #(.TIMEOUT_CYCLES(20)) u_a (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & !sel), .cmd_ready(a_cmd_ready),
      .cmd_dir(cmd_dir), .cmd_colour(cmd_colour), .drw_x(drw_x), .drw_y(drw_y),
      .drw_plot(drw_plot), .drw_done(drw_done), .drw_en(a_drw_en), .vga_x(a_vga_x),
      .vga_y(a_vga_y), .vga_colour(a_vga_colour), .vga_plot(a_vga_plot), .busy(a_busy),
      .done_pulse(a_done_pulse), .timeout_err(a_timeout_err));

   arrow_sequencer #(.BOX_W(3), .BOX_H(2), .TIMEOUT_CYCLES(5)) u_b (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
      .cmd_dir(cmd_dir), .cmd_colour(cmd_colour), .drw_x(drw_x), .drw_y(drw_y),
      .drw_plot(drw_plot), .drw_done(drw_done), .drw_en(b_drw_en), .vga_x(b_vga_x),
      .vga_y(b_vga_y), .vga_colour(b_vga_colour), .vga_plot(b_vga_plot), .busy(b_busy),
      .done_pulse(b_done_pulse), .timeout_err(b_timeout_err));

   assign outs = sel ?
      {b_cmd_ready, b_busy, b_done_pulse, b_timeout_err, b_drw_en, b_vga_plot, b_vga_colour, b_vga_x, b_vga_y} :
      {a_cmd_ready, a_busy, a_done_pulse, a_timeout_err, a_drw_en, a_vga_plot, a_vga_colour, a_vga_x, a_vga_y};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int draw_idx();
      return m_age - W*H - 1;
   endfunction

   function automatic bit in_draw();
      return m_busy && !m_fin && m_age > W*H;
   endfunction

   // expected outputs: idle / erase pixel p in raster order / drawer pass-through / finish
   function automatic logic [26:0] expected();
      logic cr, bs, dp, te, pl;
      logic [3:0] en;
      logic [2:0] c;
      logic [7:0] x;
      logic [6:0] y;
      int p;
      {cr, bs, dp, te, pl, en, c, x, y} = '0;
      if (!reset_n) return '0;
      te = m_terr;
      bs = m_busy;
      if (!m_busy) cr = 1'b1;
      else if (m_fin) dp = 1'b1;
      else if (m_age <= W*H) begin
         p  = m_age - 1;
         pl = 1'b1;
         x  = 8'(X0 + p % W);
         y  = 7'(Y0 + p / W);
      end else begin
         en = 4'b0001 << m_dir;
         c  = m_col;
         x  = drw_x[8*m_dir +: 8];
         y  = drw_y[7*m_dir +: 7];
         pl = drw_plot[m_dir];
      end
      return {cr, bs, dp, te, en, pl, c, x, y};
   endfunction

   task automatic advance();
      if (!reset_n) begin
         m_busy = 0; m_fin = 0; m_terr = 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy = 1; m_age = 1; m_dir = cmd_dir; m_col = cmd_colour; m_terr = 0;
         end
      end else if (m_fin) begin
         m_busy = 0; m_fin = 0;
      end else if (m_age <= W*H) m_age++;
      else begin
         if (drw_done[m_dir]) m_fin = 1;
         else if (draw_idx() == T - 1) begin
            m_terr = 1; m_fin = 1;
         end
         m_age++;
      end
   endtask

   task automatic drive();
      int d;
      d          = draw_idx();
      cmd_valid  = hold_valid ? 1'b1 : ($urandom % 4 == 0);
      cmd_dir    = fdir >= 0 ? 2'(fdir) : 2'($urandom);
      cmd_colour = fcol >= 0 ? 3'(fcol) : 3'($urandom);
      drw_x      = $urandom;
      drw_y      = 28'($urandom);
      drw_plot   = 4'($urandom);
      drw_done   = 4'($urandom & $urandom & $urandom);
      if (in_draw()) begin
         if (done_mode == 1) drw_done[m_dir] = 1'b0;
         if (done_mode == 2) drw_done[m_dir] = (d == done_k);
         if (pix && d < 2) begin
            drw_plot[m_dir]      = 1'b1;
            drw_x[8*m_dir +: 8] = d == 0 ? 8'd79 : 8'd78;
            drw_y[7*m_dir +: 7] = d == 0 ? 7'd63 : 7'd64;
         end
      end
      reset_n = !(rst_force || (rst_pix >= 0 && m_busy && !m_fin && m_age == rst_pix + 1));
   endtask

   task automatic step();
      #4;
      check("outs", 32'(outs), 32'(expected()));
      advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         drive();
         step();
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      rst_force = 1;
      cycles(3);
      rst_force = 0;
      // dir 0, colour 4, drawer never done: full erase then timeout, re-accept clears the error
      fdir = 0; fcol = 4; hold_valid = 1; done_mode = 1;
      cycles(2 * (256 + 23) + 10);
      // dir 2: drawer plots two known pixels then signals done
      fdir = 2; fcol = -1; hold_valid = 0; done_mode = 2; done_k = 2; pix = 1;
      cycles(900);
      // done in the very cycle of the last forwarded pixel
      done_k = 1;
      cycles(600);
      // commands held high with changing direction while busy
      fdir = -1; pix = 0; hold_valid = 1; done_mode = 0;
      cycles(1500);
      // reset pulse at erase pixel 100
      rst_pix = 100;
      cycles(700);
      rst_pix = -1; hold_valid = 0;
      cycles(400);
      // small 3x2 box, timeout 5
      sel = 1; W = 3; H = 2; T = 5;
      rst_force = 1;
      cycles(2);
      rst_force = 0;
      done_mode = 2; done_k = T - 1;
      cycles(300);
      done_mode = 1;
      cycles(200);
      done_mode = 0; hold_valid = 1;
      cycles(800);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
